// File: rtl/fp_minmax_reduce_d.sv
// Purpose : sequential IEEE-754 double min/max reduction, one operand folded per cycle.
// Latency : result valid the cycle after the last operand handshake (count=0: cycle after start).
// Backpr. : input taken only on i_in_valid&o_in_ready; result held stable until i_out_ready.
//
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_start, i_op, i_count   reduction request (op 0=min 1=max), honoured only when idle
//   i_in_valid/o_in_ready    operand stream handshake, i_in_data operand
//   o_out_valid/i_out_ready  result handshake, o_out_data result, o_out_nv invalid flag
//   o_busy                   engine not idle
module fp_minmax_reduce_d #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [63:0]      i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [63:0]      o_out_data,
  output logic             o_out_nv,
  output logic             o_busy
);

  localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_ACCUM, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_op;
  logic [CNT_W-1:0] r_rem;
  logic [63:0]      r_acc;
  logic             r_nv;

  logic             w_hs;
  logic             w_last;
  logic [63:0]      w_minmax;

  function automatic logic f_is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  function automatic logic f_is_snan(input logic [63:0] x);
    return f_is_nan(x) && !x[51];
  endfunction

  // Sign/magnitude ordering: with differing signs the negative one is smaller,
  // which also puts -0 below +0. Same-sign negatives invert magnitude order.
  function automatic logic [63:0] f_minmax(input logic [63:0] a, input logic [63:0] b,
                                           input logic is_max);
    logic        a_lt_b;
    logic [63:0] res;
    if (a[63] != b[63])  a_lt_b = a[63];
    else if (a[63])      a_lt_b = (a[62:0] > b[62:0]);
    else                 a_lt_b = (a[62:0] < b[62:0]);
    if (f_is_nan(a) && f_is_nan(b)) res = CANON_NAN;
    else if (f_is_nan(a))           res = b;
    else if (f_is_nan(b))           res = a;
    else if (is_max)                res = a_lt_b ? b : a;
    else                            res = a_lt_b ? a : b;
    return res;
  endfunction

  assign o_in_ready  = ((r_state == S_FIRST) || (r_state == S_ACCUM)) && (r_rem != '0);
  assign o_out_valid = (r_state == S_DONE);
  assign o_busy      = (r_state != S_IDLE);
  // A NaN can only sit in the accumulator if it arrived in the first slot
  // (or every operand was NaN), so canonicalise on the way out.
  assign o_out_data  = f_is_nan(r_acc) ? CANON_NAN : r_acc;
  assign o_out_nv    = r_nv && (r_state == S_DONE);

  assign w_hs     = i_in_valid && o_in_ready;
  assign w_last   = (r_rem == CNT_W'(1));
  assign w_minmax = f_minmax(r_acc, i_in_data, r_op);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = (i_count == '0) ? S_DONE : S_FIRST;
      S_FIRST: if (w_hs)    w_state_nxt = w_last ? S_DONE : S_ACCUM;
      S_ACCUM: if (w_hs && w_last) w_state_nxt = S_DONE;
      S_DONE:  if (i_out_ready)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op  <= 1'b0;
      r_rem <= '0;
      r_acc <= 64'd0;
      r_nv  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op  <= i_op;
            r_rem <= i_count;
            r_nv  <= 1'b0;
            if (i_count == '0) r_acc <= CANON_NAN;
          end
        end
        S_FIRST: begin
          if (w_hs) begin
            r_acc <= i_in_data;
            r_rem <= r_rem - CNT_W'(1);
          end
        end
        S_ACCUM: begin
          if (w_hs) begin
            r_acc <= w_minmax;
            r_rem <= r_rem - CNT_W'(1);
          end
        end
        default: ;
      endcase
      // Sticky invalid: any consumed signaling NaN, first operand included.
      if (w_hs && f_is_snan(i_in_data)) r_nv <= 1'b1;
    end
  end

endmodule

// File: doc/fp_minmax_reduce_d.md
# fp_minmax_reduce_d

Sequential min/max reduction engine for IEEE-754 double-precision operands, built around the combinational FP min/max datapath of the RISC D ALU. It accepts a programmed number of operands over a valid/ready stream, folds them one per cycle into a running accumulator, and emits a single result. It serves vector reduction (`vfredmin/vfredmax`-style) sequences and library `fmin`/`fmax` loops without stalling the main ALU.

## Interface
- `CNT_W`, default 8: width of the element-count field; maximum reduction length is 2^CNT_W−1.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a reduction; honoured only in IDLE.
- `op`  in  1  0 = min, 1 = max; latched on accepted `start`.
- `count`  in  CNT_W  number of elements; latched on accepted `start`.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  engine accepts an operand this cycle.
- `in_data`  in  64  operand in IEEE-754 double format.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  64  reduction result.
- `out_nv`  out  1  invalid flag: at least one signaling NaN was consumed in this reduction.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FIRST, ACCUM, DONE. All outputs come from registered state.
- IDLE: `in_ready`=0. When `start`=1, latch `op` and `count`, and clear the sticky NV bit.
  - If `count`==0: set acc=0x7FF8000000000000 and go to DONE.
  - Otherwise set rem=`count` and go to FIRST.
- FIRST: `in_ready`=1. On handshake (`in_valid` & `in_ready`):
  - set acc=`in_data` and rem=rem−1;
  - if rem was 1, go to DONE; otherwise go to ACCUM.
- ACCUM: `in_ready`=1. On handshake:
  - set acc=minmax(acc, `in_data`, op) and rem=rem−1;
  - if rem was 1, go to DONE.
- DONE: `out_valid`=1. `out_data` is acc, except that a NaN acc is output as canonical 0x7FF8000000000000. On `out_ready`, go to IDLE.
- Pairwise minmax rules (RISC-V `fmin.d`/`fmax.d`):
  - both operands NaN → canonical NaN;
  - exactly one NaN → the other operand;
  - −0 is ordered below +0, so min(+0,−0)=−0 and max(+0,−0)=+0; same-sign zeros return that zero;
  - otherwise sign/magnitude ordering; when operands are equal, either may be returned (bit-identical).
- NaN classification:
  - NaN: exp=0x7FF and frac≠0.
  - sNaN: NaN with frac[51]=0. Any consumed sNaN sets sticky NV, including in FIRST. `out_nv` reflects NV in DONE.
- rem is CNT_W bits and never wraps: a handshake is impossible when rem=0.
- `start` outside IDLE is ignored. `start` and a DONE handshake in the same cycle: DONE→IDLE only; the next reduction needs a new `start`.
- `in_data` is ignored when `in_valid`=0. Extra operands beyond `count` are not accepted (`in_ready`=0).

## Timing
- Reset (`rst_n`=0 at a clock edge) → state IDLE, acc=0, rem=0, NV=0. Resulting outputs: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_nv`=0, `busy`=0.
- Reset mid-reduction aborts it; partial results are discarded.
- `start` accepted at edge t → `in_ready`=1 and `busy`=1 from cycle t+1.
- Throughput: one operand per cycle with no bubbles.
- Latency: with `in_valid` held high, the last operand is accepted at edge t+count. `out_valid` rises in the following cycle: cycle t+count+1 after `start`. For `count`=0, `out_valid` is high at t+1.
- `out_data` and `out_nv` stay stable while `out_valid`=1 and `out_ready`=0.
- `out_valid` drops the cycle after the handshake. `busy` stays high through DONE.

## Test plan
- **Max of three:** `op`=1, `count`=3, inputs 0x3FF0000000000000, 0xC000000000000000, 0x400C000000000000 back-to-back → `out_data`=0x400C000000000000, `out_nv`=0, `out_valid` high 4 cycles after `start`.
- **Signed zeros:** `count`=2, inputs 0x0000000000000000 then 0x8000000000000000.
  - min → 0x8000000000000000;
  - max → 0x0000000000000000;
  - min of {+0,+0} → 0x0000000000000000.
- **NaN handling:**
  - min of {0x7FF8000000000000, 0x4014000000000000} → 0x4014000000000000, `out_nv`=0;
  - max of {0x7FF0000000000001, 0x7FF8000000000000} → 0x7FF8000000000000, `out_nv`=1.
- **Zero count:** `count`=0 → `out_data`=0x7FF8000000000000 with `out_valid` one cycle after `start`; `in_ready` never asserts.
- **Back-pressure:** `in_valid` toggled 1,0,0,1,1 for `count`=3, then `out_ready` held low 3 cycles with `start` pulsed.
  - Operands are taken only on handshakes.
  - `out_data` is stable and `start` is ignored.
  - Result clears on the 4th cycle.
- **Reset mid-reduction:** `rst_n`=0 in ACCUM after 2 of 5 operands → next cycle all outputs at reset values. A fresh `start` with `count`=1 and input 0xBFF0000000000000 → result 0xBFF0000000000000.
